// File: rtl/mult_block_engine.sv
// Multiply / multiply-accumulate engine: fills memory addresses 0..N-1 with results, then streams the block back.
// Optional macro MULT_SATURATE_EN: accumulate mode clamps at 2**WIDTH-1 instead of wrapping.
module mult_block_engine #(
  parameter int IN_WIDTH   = 16,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN_mult,
  input  logic [IN_WIDTH-1:0]   mult_input0,
  input  logic [IN_WIDTH-1:0]   mult_input1,
  input  logic                  acc_mode,
  output logic                  RDY_mult,
  output logic                  EN_writeMem,
  output logic [ADDR_WIDTH-1:0] writeMem_addr,
  output logic [WIDTH-1:0]      writeMem_val,
  input  logic                  EN_blockRead,
  output logic                  EN_readMem,
  output logic [ADDR_WIDTH-1:0] readMem_addr,
  input  logic [WIDTH-1:0]      readMem_val,
  output logic                  VALID_memVal,
  output logic [WIDTH-1:0]      memVal_data,
  output logic                  LAST_memVal
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WRITE, DRAIN, DONE, READ} state_t;

  state_t stateReg, stateNext;
  logic rdy, readEn, accept, startBlock;

  logic [CW-1:0]         writeCount;
  logic                  accMode;
  logic [WIDTH-1:0]      accReg;
  logic                  opValid;
  logic [IN_WIDTH-1:0]   opA, opB;
  logic [ADDR_WIDTH-1:0] opAddr;

  logic [ADDR_WIDTH-1:0] rdAddr, lastAddr;
  logic                  rdPending, rdPendingLast;

  logic [2*IN_WIDTH-1:0] prodRaw;
  logic [WIDTH-1:0]      product, accSum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    rdy       = 1'b0;
    readEn    = 1'b0;
    case (stateReg)
      IDLE: begin
        rdy = 1'b1;
        if (EN_mult) stateNext = WRITE;
      end
      WRITE: begin
        rdy = (writeCount < DEPTH_C);
        if (!EN_mult || writeCount == LAST_C) stateNext = DRAIN;
      end
      DRAIN: begin
        // the final write leaves stage two on this edge, so the block is complete
        if (!opValid) stateNext = DONE;
      end
      DONE: begin
        rdy = !EN_blockRead;
        if (EN_blockRead) stateNext = READ;
        else if (EN_mult) stateNext = WRITE;
      end
      READ: begin
        readEn = 1'b1;
        if (rdAddr == lastAddr) stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign RDY_mult     = rdy & ~rst;
  assign accept       = EN_mult & rdy;
  assign startBlock   = accept & ((stateReg == IDLE) || (stateReg == DONE));
  assign EN_readMem   = readEn;
  assign readMem_addr = rdAddr;
  assign lastAddr     = writeCount[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  assign prodRaw = {{IN_WIDTH{1'b0}}, opA} * {{IN_WIDTH{1'b0}}, opB};
  assign product = WIDTH'(prodRaw);

`ifdef MULT_SATURATE_EN
  logic [WIDTH:0] accWide;
  assign accWide = {1'b0, accReg} + {1'b0, product};
  // once clamped, any further addition overflows again, so the clamp sticks
  assign accSum  = accWide[WIDTH] ? {WIDTH{1'b1}} : accWide[WIDTH-1:0];
`else
  assign accSum  = accReg + product;
`endif

  // write pipeline: operand register, then product/accumulate register driving the memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeCount    <= '0;
      accMode       <= 1'b0;
      accReg        <= '0;
      opValid       <= 1'b0;
      opA           <= '0;
      opB           <= '0;
      opAddr        <= '0;
      EN_writeMem   <= 1'b0;
      writeMem_addr <= '0;
      writeMem_val  <= '0;
    end else begin
      opValid     <= accept;
      EN_writeMem <= opValid;
      if (accept) begin
        opA    <= mult_input0;
        opB    <= mult_input1;
        opAddr <= startBlock ? '0 : writeCount[ADDR_WIDTH-1:0];
      end
      if (opValid) begin
        writeMem_addr <= opAddr;
        writeMem_val  <= accMode ? accSum : product;
        if (accMode) accReg <= accSum;
      end
      if (startBlock) begin
        writeCount <= CW'(1);
        accMode    <= acc_mode;
        accReg     <= '0;
      end else if (accept) begin
        writeCount <= writeCount + CW'(1);
      end
    end
  end

  // read pipeline: address issue, memory latency, registered output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdAddr        <= '0;
      rdPending     <= 1'b0;
      rdPendingLast <= 1'b0;
      VALID_memVal  <= 1'b0;
      LAST_memVal   <= 1'b0;
      memVal_data   <= '0;
    end else begin
      if (readEn) rdAddr <= (rdAddr == lastAddr) ? '0 : rdAddr + ADDR_WIDTH'(1);
      rdPending     <= readEn;
      rdPendingLast <= readEn && (rdAddr == lastAddr);
      VALID_memVal  <= rdPending;
      LAST_memVal   <= rdPending & rdPendingLast;
      if (rdPending) memVal_data <= readMem_val;
    end
  end

endmodule

// File: tb/tb_mult_block_engine.sv
// Directed bench for mult_block_engine with a behavioural two-port memory and write/read scoreboards.
module tb_mult_block_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN_mult;
  logic [15:0] mult_input0, mult_input1;
  logic        acc_mode;
  logic        RDY_mult;
  logic        EN_writeMem;
  logic [5:0]  writeMem_addr;
  logic [31:0] writeMem_val;
  logic        EN_blockRead;
  logic        EN_readMem;
  logic [5:0]  readMem_addr;
  logic [31:0] readMem_val;
  logic        VALID_memVal;
  logic [31:0] memVal_data;
  logic        LAST_memVal;

  mult_block_engine #(.IN_WIDTH(16), .WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .EN_mult(EN_mult), .mult_input0(mult_input0),
    .mult_input1(mult_input1), .acc_mode(acc_mode), .RDY_mult(RDY_mult),
    .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
    .EN_blockRead(EN_blockRead), .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
    .readMem_val(readMem_val), .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .LAST_memVal(LAST_memVal)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
    if (EN_readMem) readMem_val <= mem[readMem_addr];
  end

  int checks = 0;
  int errors = 0;
  int validSeen = 0;
  logic [31:0] lastStream = '0;
  logic [37:0] wq[$];
  logic [32:0] rq[$];
  logic [31:0] modelMem [64];
  logic [31:0] modelAcc;
  int modelN = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (EN_writeMem) begin
        chk("unexpected_write", 96'(wq.size() > 0), 96'(1));
        if (wq.size() > 0) chk("write_addr_val", 96'({writeMem_addr, writeMem_val}), 96'(wq.pop_front()));
      end
      if (VALID_memVal) begin
        validSeen++;
        chk("unexpected_read", 96'(rq.size() > 0), 96'(1));
        if (rq.size() > 0) chk("read_last_data", 96'({LAST_memVal, memVal_data}), 96'(rq.pop_front()));
        if (LAST_memVal) lastStream = memVal_data;
      end else if (LAST_memVal) begin
        chk("last_without_valid", 96'(LAST_memVal), 96'(0));
      end
    end
  end

  task automatic calcVal(input logic [15:0] a, input logic [15:0] b, input logic mode,
                         output logic [31:0] v);
    logic [31:0] p;
    logic [32:0] s;
    p = 32'(a) * 32'(b);
    if (!mode) begin
      v = p;
    end else begin
      s = {1'b0, modelAcc} + {1'b0, p};
`ifdef MULT_SATURATE_EN
      if (s[32]) s = {1'b0, 32'hFFFF_FFFF};
`endif
      modelAcc = s[31:0];
      v = modelAcc;
    end
  endtask

  // pat 0: a=i,b=i  1: a=1,b=i  2: a=2,b=3  3: a=b=0xFFFF
  task automatic runBlock(input int n, input logic mode, input int pat);
    logic [15:0] a, b;
    logic [31:0] v;
    modelAcc = '0;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0: begin a = 16'(i); b = 16'(i); end
        1: begin a = 16'd1; b = 16'(i); end
        2: begin a = 16'd2; b = 16'd3; end
        default: begin a = 16'hFFFF; b = 16'hFFFF; end
      endcase
      EN_mult = 1'b1; mult_input0 = a; mult_input1 = b;
      acc_mode = (i == 0) ? mode : ~mode;
      chk("rdy_accept", 96'(RDY_mult), 96'(1));
      calcVal(a, b, mode, v);
      modelMem[i] = v;
      wq.push_back({6'(i), v});
      @(posedge clk); #1;
    end
    EN_mult = 1'b0; acc_mode = 1'b0;
    modelN = n;
    if (n == 64) chk("rdy_full_drop", 96'(RDY_mult), 96'(0));
    repeat (4) @(posedge clk);
    #1;
    chk("write_drain", 96'(wq.size()), 96'(0));
    chk("rdy_done", 96'(RDY_mult), 96'(1));
  endtask

  task automatic readBlock(input logic alsoMult);
    for (int i = 0; i < modelN; i++) rq.push_back({(i == modelN - 1), modelMem[i]});
    EN_blockRead = 1'b1;
    if (alsoMult) begin
      EN_mult = 1'b1; mult_input0 = 16'd7; mult_input1 = 16'd9;
    end
    #1;
    chk("rdy_forced_low", 96'(RDY_mult), 96'(0));
    @(posedge clk); #1;
    EN_blockRead = 1'b0; EN_mult = 1'b0;
    chk("rdy_in_read", 96'(RDY_mult), 96'(0));
    chk("read_start", 96'({EN_readMem, readMem_addr}), 96'({1'b1, 6'd0}));
    for (int c = 0; c < modelN + 8 && rq.size() > 0; c++) @(posedge clk);
    #1;
    chk("read_complete", 96'(rq.size()), 96'(0));
  endtask

  initial begin
    int seen;
    int base;
    logic [31:0] ovfExp;
    rst = 1'b1; EN_mult = 1'b0; mult_input0 = '0; mult_input1 = '0;
    acc_mode = 1'b0; EN_blockRead = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 96'({RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem,
                              readMem_addr, VALID_memVal, memVal_data, LAST_memVal}), 96'(0));
    rst = 1'b0;
    #1;
    chk("rdy_after_reset", 96'(RDY_mult), 96'(1));

    // EN_blockRead is ignored in IDLE
    @(posedge clk); #1;
    EN_blockRead = 1'b1;
    @(posedge clk); #1;
    EN_blockRead = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_read_ignored", 96'({validSeen[7:0], RDY_mult}), 96'({8'd0, 1'b1}));

    runBlock(64, 1'b0, 0);
    readBlock(1'b0);
    chk("product_last_word", 96'(lastStream), 96'(32'd3969));

    runBlock(64, 1'b1, 1);
    readBlock(1'b0);
    chk("acc_last_word", 96'(lastStream), 96'(32'd2016));

    runBlock(10, 1'b0, 2);
    readBlock(1'b0);
    chk("partial_last_word", 96'(lastStream), 96'(32'd6));
    readBlock(1'b0);
    chk("partial_reread", 96'(lastStream), 96'(32'd6));

    runBlock(2, 1'b1, 3);
    readBlock(1'b0);
`ifdef MULT_SATURATE_EN
    ovfExp = 32'hFFFF_FFFF;
`else
    ovfExp = 32'hFFFC_0002;
`endif
    chk("overflow_word", 96'(lastStream), 96'(ovfExp));

    // read and operand on the same DONE edge: read wins, nothing written
    readBlock(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("same_edge_no_write", 96'(wq.size()), 96'(0));

    // reset in the middle of a read stream
    runBlock(64, 1'b0, 0);
    for (int i = 0; i < modelN; i++) rq.push_back({(i == modelN - 1), modelMem[i]});
    EN_blockRead = 1'b1;
    @(posedge clk); #1;
    EN_blockRead = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 5; c++) begin
      @(posedge clk); #1;
      if (VALID_memVal) seen++;
    end
    chk("reached_fifth_word", 96'(seen), 96'(5));
    rst = 1'b1;
    #1;
    chk("midread_reset_outputs", 96'({RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem,
                                      readMem_addr, VALID_memVal, memVal_data, LAST_memVal}), 96'(0));
    rq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rdy_after_midread_reset", 96'(RDY_mult), 96'(1));
    base = validSeen;
    @(posedge clk); #1;
    EN_blockRead = 1'b1;
    @(posedge clk); #1;
    EN_blockRead = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("no_stream_after_reset", 96'(validSeen - base), 96'(0));
    chk("idle_after_reset", 96'(RDY_mult), 96'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_block_engine.md
# mult_block_engine

Parametrised multiply/multiply-accumulate engine that fills a block of a two-port memory with results, then streams that block back out. It accepts one operand pair per cycle, computes the unsigned product or a running sum of products, and writes each result to consecutive memory addresses from 0. It supports partial blocks, a last-word marker and optional saturating accumulation. It sits between an operand source and a `memory_wrapper_2port` instance: write port B, read port A, one-cycle read latency.

## Interface
- `IN_WIDTH`, 16, operand width (unsigned).
- `WIDTH`, 32, result/memory word width; must be >= 2*IN_WIDTH.
- `ADDR_WIDTH`, 6, memory address width; DEPTH = 2**ADDR_WIDTH.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `EN_mult`  in  1  operand pair valid; accepted on an edge where `EN_mult && RDY_mult`.
- `mult_input0`, `mult_input1`  in  IN_WIDTH  operands.
- `acc_mode`  in  1  0 = store product, 1 = store running sum; sampled on the first accept of a block.
- `RDY_mult`  out  1  engine can accept an operand pair.
- `EN_writeMem`  out  1  memory write enable (active-high; the wrapper takes its inverse).
- `writeMem_addr`  out  ADDR_WIDTH  write address.
- `writeMem_val`  out  WIDTH  write data.
- `EN_blockRead`  in  1  pulse; starts streaming the stored block.
- `EN_readMem`  out  1  memory read enable.
- `readMem_addr`  out  ADDR_WIDTH  read address.
- `readMem_val`  in  WIDTH  memory read data, valid one cycle after `EN_readMem`.
- `VALID_memVal`  out  1  `memVal_data` valid this cycle.
- `memVal_data`  out  WIDTH  streamed word.
- `LAST_memVal`  out  1  high with the final word of the block.

## Operation
- States: IDLE, WRITE, DRAIN, DONE, READ.
- **IDLE**
  - `RDY_mult` = 1.
  - An accept clears the write count, latches `acc_mode`, clears the accumulator, and goes to WRITE.
  - `EN_blockRead` is ignored in IDLE.
- **WRITE**
  - `RDY_mult` = 1 while accepted count < DEPTH.
  - Accepted pair k goes to address k.
  - Go to DRAIN when `EN_mult` is low on an edge or when the DEPTH-th pair is accepted.
- **DRAIN**
  - `RDY_mult` = 0.
  - Wait until the write pipeline is empty, then go to DONE.
  - The stored count N (1..DEPTH) is held.
- **DONE**
  - `RDY_mult` = 1.
  - `EN_blockRead` goes to READ.
  - An accept starts a new block, as in IDLE.
  - If both occur on the same edge, the read wins and the operand is not accepted: `RDY_mult` is forced 0 in any cycle where `EN_blockRead` is high in DONE.
- **READ**
  - `RDY_mult` = 0.
  - Issue `EN_readMem` for addresses 0..N-1 on consecutive cycles.
  - Each returned word is presented one cycle later with `VALID_memVal`; `LAST_memVal` is set on word N-1.
  - Go to DONE after the last word, so the same block can be re-read.
- Arithmetic:
  - product = `mult_input0 * mult_input1`, unsigned, zero-extended to WIDTH.
  - Accumulate mode: acc <= acc + product, modulo 2**WIDTH; the value written is the new acc.
- `EN_mult` outside IDLE/WRITE/DONE, and `EN_blockRead` outside DONE, are ignored.
- Reset, including mid-block or mid-read:
  - state IDLE; count, accumulator and pipeline cleared.
  - All outputs 0 except `RDY_mult` = 1 after reset releases.
  - Memory contents are not cleared.

## Timing
- Write latency 2:
  - Pair accepted at edge k.
  - Product registered at edge k+1.
  - `EN_writeMem`/`writeMem_addr`/`writeMem_val` valid in the cycle after edge k+1; memory writes at edge k+2.
- Throughput: one pair per cycle; a full block takes DEPTH+2 cycles from first accept to DONE.
- Read latency:
  - `EN_blockRead` sampled at edge r.
  - `EN_readMem` for address 0 is high in the cycle after edge r.
  - `VALID_memVal` for word i is high in the cycle after the edge where address i is read.
  - The stream is N contiguous valid cycles.
- `memVal_data` is registered and holds its last value while `VALID_memVal` = 0. `LAST_memVal` is high only when `VALID_memVal` is high.
- Reset values: `EN_writeMem`, `EN_readMem`, `VALID_memVal`, `LAST_memVal` = 0; all buses = 0; `RDY_mult` = 0 while `rst` is high.

## Configuration
- `MULT_SATURATE_EN` defined: in accumulate mode, a sum exceeding 2**WIDTH-1 clamps to 2**WIDTH-1 and stays there for the rest of the block.
- `MULT_SATURATE_EN` undefined: the accumulator wraps modulo 2**WIDTH.
- Product mode is unaffected by the macro.

## Test plan
- Product mode, full block, a=i, b=i for i=0..63:
  - `RDY_mult` drops after the 64th accept.
  - Read streams 0,1,4,...,3969 with `LAST_memVal` only on 3969.
- Accumulate mode, a=1, b=i for i=0..63: addr i holds i(i+1)/2; the streamed last word is 2016.
- Partial block: 10 pairs a=2, b=3, then `EN_mult` low → read streams exactly ten 6s, `LAST_memVal` on the 10th; a second `EN_blockRead` repeats the same stream.
- Overflow, accumulate mode, two pairs a=b=0xFFFF:
  - First write is 0xFFFE0001.
  - Second write is 0xFFFC0002 without `MULT_SATURATE_EN` and 0xFFFFFFFF with it.
- `EN_blockRead` and `EN_mult` high on the same edge in DONE → read stream starts, nothing is written, no operand is accepted.
- Reset after the 5th valid read word:
  - All outputs 0 immediately.
  - After release, `RDY_mult` = 1.
  - A following `EN_blockRead` with no new block yields no `VALID_memVal`.
